// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter: default widths,
// FSM state encodings and the streak counter sizing helper.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_BUSY_I = 2'b01,
    ST_BUSY_D = 2'b10
  } state_t;

  // Width needed to count 0..max inclusive; never narrower than one bit.
  function automatic int unsigned streak_w(input int unsigned max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_arb_select.sv
// Grant selection between fetch and data requesters, plus next value of the
// data-grant streak used to bound how long a pending fetch can be starved.
module arb_select
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 2,
  parameter int unsigned STREAK_W   = streak_w(STARVE_MAX)
) (
  input  logic                i_en,
  input  logic                i_ireq,
  input  logic                i_dreq,
  input  logic                i_i_block,
  input  logic                i_d_block,
  input  logic [STREAK_W-1:0] i_streak,
  output logic                o_grant_i,
  output logic                o_grant_d,
  output logic [STREAK_W-1:0] o_streak_nxt
);

  logic w_i_elig;
  logic w_d_elig;
  logic w_sat;

  // A requester whose valid pulse is high this cycle is still holding req for
  // the access that just finished, so it must not be granted again.
  assign w_i_elig = i_ireq & ~i_i_block;
  assign w_d_elig = i_dreq & ~i_d_block;
  assign w_sat    = (i_streak == STREAK_W'(STARVE_MAX));

  assign o_grant_d = i_en & w_d_elig & ~(w_i_elig & w_sat);
  assign o_grant_i = i_en & w_i_elig & ~o_grant_d;

  always_comb begin
    o_streak_nxt = i_streak;
    if (o_grant_i) begin
      o_streak_nxt = '0;
    end else if (o_grant_d && i_ireq && !w_sat) begin
      o_streak_nxt = i_streak + STREAK_W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch and load/store) sharing one memory port. One
// access in flight at a time; memory signals are registered for the whole access.
//
// state     | meaning
// ST_IDLE   | no access; arbitrate eligible requests
// ST_BUSY_I | fetch access on the memory port, waiting for mem_ready
// ST_BUSY_D | load/store access on the memory port, waiting for mem_ready
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned STARVE_MAX = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);

  localparam int unsigned STREAK_W = streak_w(STARVE_MAX);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [STREAK_W-1:0] r_d_streak;
  logic [STREAK_W-1:0] w_streak_nxt;
  logic                w_grant_i;
  logic                w_grant_d;
  logic                w_idle;
  logic                w_busy;

  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_i_valid;
  logic                r_d_valid;
  logic [DATA_W-1:0]   r_i_rdata;
  logic [DATA_W-1:0]   r_d_rdata;

  assign w_idle = (r_state == ST_IDLE);

  arb_select #(
    .STARVE_MAX (STARVE_MAX),
    .STREAK_W   (STREAK_W)
  ) u_arb_select (
    .i_en         (w_idle),
    .i_ireq       (i_req),
    .i_dreq       (d_req),
    .i_i_block    (r_i_valid),
    .i_d_block    (r_d_valid),
    .i_streak     (r_d_streak),
    .o_grant_i    (w_grant_i),
    .o_grant_d    (w_grant_d),
    .o_streak_nxt (w_streak_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_d) begin
          w_state_nxt = ST_BUSY_D;
        end else if (w_grant_i) begin
          w_state_nxt = ST_BUSY_I;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (mem_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    if (r_state != ST_IDLE) begin
      w_busy = 1'b1;
    end
  end

  // Address/data registers are loaded only at grant time, so they stay stable
  // for however many wait cycles the memory inserts.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_d_streak  <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_valid   <= 1'b0;
      r_d_valid   <= 1'b0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_d_streak <= w_streak_nxt;
      r_i_valid  <= 1'b0;
      r_d_valid  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_d) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= d_we;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_wdata;
          end else if (w_grant_i) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= i_addr;
            r_mem_wdata <= '0;
          end
        end
        ST_BUSY_I: begin
          if (mem_ready) begin
            r_mem_req <= 1'b0;
            r_i_valid <= 1'b1;
            r_i_rdata <= mem_rdata;
          end
        end
        ST_BUSY_D: begin
          if (mem_ready) begin
            r_mem_req <= 1'b0;
            r_d_valid <= 1'b1;
            if (!r_mem_we) begin
              r_d_rdata <= mem_rdata;
            end
          end
        end
        default: r_mem_req <= 1'b0;
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign i_valid   = r_i_valid;
  assign d_valid   = r_d_valid;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
  assign busy      = w_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change 1 time unit after a rising edge,
// outputs are sampled at the same point, so each tick shows one clock's update.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_valid;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_valid   (i_valid),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_valid   (d_valid),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = 32'h1234_5678; mem_ready = 1'b1;
    tick(); tick();
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_mem_req got=%0h exp=0", mem_req); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%0h exp=0", busy); end
    n_cmp++; if ({i_valid, d_valid} !== 2'b00) begin n_err++; $display("FAIL rst_valids got=%0b exp=00", {i_valid, d_valid}); end
    n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== 65'h0) begin n_err++; $display("FAIL rst_mem_regs got=%0h exp=0", {mem_we, mem_addr, mem_wdata}); end
    n_cmp++; if ({i_rdata, d_rdata} !== 64'h0) begin n_err++; $display("FAIL rst_rdata got=%0h exp=0", {i_rdata, d_rdata}); end
    reset = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_idle_ready_ignored got=%0h exp=0", busy); end
  endtask

  task automatic test_single_fetch();
    mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF; i_req = 1'b1; i_addr = 32'h10;
    tick();
    n_cmp++; if ({mem_req, busy, mem_we} !== 3'b110) begin n_err++; $display("FAIL fetch_c1_ctrl got=%0b exp=110", {mem_req, busy, mem_we}); end
    n_cmp++; if (mem_addr !== 32'h10) begin n_err++; $display("FAIL fetch_c1_addr got=%0h exp=10", mem_addr); end
    n_cmp++; if (i_valid !== 1'b0) begin n_err++; $display("FAIL fetch_c1_valid got=%0h exp=0", i_valid); end
    tick();
    n_cmp++; if (i_valid !== 1'b1) begin n_err++; $display("FAIL fetch_c2_valid got=%0h exp=1", i_valid); end
    n_cmp++; if (i_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL fetch_c2_rdata got=%0h exp=deadbeef", i_rdata); end
    n_cmp++; if ({mem_req, busy} !== 2'b00) begin n_err++; $display("FAIL fetch_c2_idle got=%0b exp=00", {mem_req, busy}); end
    i_req = 1'b0; mem_rdata = 32'h0BAD_0BAD;
    tick();
    n_cmp++; if (i_valid !== 1'b0) begin n_err++; $display("FAIL fetch_c3_pulse got=%0h exp=0", i_valid); end
    n_cmp++; if (i_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL fetch_c3_hold got=%0h exp=deadbeef", i_rdata); end
  endtask

  task automatic test_wait_states();
    mem_ready = 1'b0; mem_rdata = 32'hCAFE_0001;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_wdata = 32'h99;
    tick();
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h80}) begin n_err++; $display("FAIL wait_stable_%0d got=%0h exp=%0h", k, {mem_req, mem_we, mem_addr}, {2'b10, 32'h80}); end
      n_cmp++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL wait_no_valid_%0d got=%0h exp=0", k, d_valid); end
      if (k == 3) mem_ready = 1'b1;
      tick();
    end
    n_cmp++; if (d_valid !== 1'b1) begin n_err++; $display("FAIL wait_valid got=%0h exp=1", d_valid); end
    n_cmp++; if (d_rdata !== 32'hCAFE_0001) begin n_err++; $display("FAIL wait_rdata got=%0h exp=cafe0001", d_rdata); end
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL wait_req_drop got=%0h exp=0", mem_req); end
    d_req = 1'b0;
    tick();
    n_cmp++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL wait_single_pulse got=%0h exp=0", d_valid); end
  endtask

  task automatic test_simultaneous();
    mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
    i_req = 1'b1; i_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h5;
    tick();
    n_cmp++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h40, 32'h5}) begin n_err++; $display("FAIL simul_d_first got=%0h exp=%0h", {mem_req, mem_we, mem_addr, mem_wdata}, {2'b11, 32'h40, 32'h5}); end
    tick();
    n_cmp++; if (d_valid !== 1'b1) begin n_err++; $display("FAIL simul_d_valid got=%0h exp=1", d_valid); end
    n_cmp++; if (d_rdata !== 32'hCAFE_0001) begin n_err++; $display("FAIL simul_store_rdata got=%0h exp=cafe0001", d_rdata); end
    d_req = 1'b0;
    tick();
    n_cmp++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b10, 32'h20, 32'h0}) begin n_err++; $display("FAIL simul_i_second got=%0h exp=%0h", {mem_req, mem_we, mem_addr, mem_wdata}, {2'b10, 32'h20, 32'h0}); end
    tick();
    n_cmp++; if ({i_valid, i_rdata} !== {1'b1, 32'h1111_2222}) begin n_err++; $display("FAIL simul_i_done got=%0h exp=%0h", {i_valid, i_rdata}, {1'b1, 32'h1111_2222}); end
    i_req = 1'b0;
    tick();
  endtask

  // i_req is lowered only during each d_valid cycle so that slot cannot go
  // to the fetch; this isolates the streak limit as the reason I finally wins.
  task automatic test_starvation();
    mem_ready = 1'b1; mem_rdata = 32'h0;
    i_req = 1'b1; i_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h7;
    tick();
    n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 32'h100}) begin n_err++; $display("FAIL starve_grant1_d got=%0h exp=%0h", {mem_req, mem_addr}, {1'b1, 32'h100}); end
    tick();
    i_req = 1'b0;
    tick();
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL starve_gap1 got=%0h exp=0", mem_req); end
    i_req = 1'b1;
    tick();
    n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 32'h100}) begin n_err++; $display("FAIL starve_grant2_d got=%0h exp=%0h", {mem_req, mem_addr}, {1'b1, 32'h100}); end
    tick();
    i_req = 1'b0;
    tick();
    i_req = 1'b1;
    tick();
    n_cmp++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h200}) begin n_err++; $display("FAIL starve_grant3_i got=%0h exp=%0h", {mem_req, mem_we, mem_addr}, {2'b10, 32'h200}); end
    tick();
    n_cmp++; if (i_valid !== 1'b1) begin n_err++; $display("FAIL starve_i_valid got=%0h exp=1", i_valid); end
    i_req = 1'b0; d_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    mem_ready = 1'b0; i_req = 1'b1; i_addr = 32'h300;
    tick();
    n_cmp++; if ({mem_req, busy} !== 2'b11) begin n_err++; $display("FAIL rmid_busy got=%0b exp=11", {mem_req, busy}); end
    tick();
    reset = 1'b1;
    tick();
    n_cmp++; if ({mem_req, busy, i_valid} !== 3'b000) begin n_err++; $display("FAIL rmid_abandon got=%0b exp=000", {mem_req, busy, i_valid}); end
    reset = 1'b0; i_req = 1'b0; mem_ready = 1'b1;
    tick();
    n_cmp++; if ({mem_req, i_valid, i_rdata} !== 34'h0) begin n_err++; $display("FAIL rmid_after got=%0h exp=0", {mem_req, i_valid, i_rdata}); end
  endtask

  task automatic test_held_req();
    mem_ready = 1'b1; mem_rdata = 32'hABCD_0001; i_req = 1'b1; i_addr = 32'h44;
    tick();
    n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL held_grant1 got=%0h exp=1", mem_req); end
    tick();
    n_cmp++; if ({i_valid, mem_req, busy} !== 3'b100) begin n_err++; $display("FAIL held_valid got=%0b exp=100", {i_valid, mem_req, busy}); end
    tick();
    n_cmp++; if ({i_valid, mem_req, busy} !== 3'b000) begin n_err++; $display("FAIL held_no_double got=%0b exp=000", {i_valid, mem_req, busy}); end
    mem_rdata = 32'hABCD_0002;
    tick();
    n_cmp++; if ({mem_req, busy, mem_addr} !== {2'b11, 32'h44}) begin n_err++; $display("FAIL held_regrant got=%0h exp=%0h", {mem_req, busy, mem_addr}, {2'b11, 32'h44}); end
    tick();
    n_cmp++; if ({i_valid, i_rdata} !== {1'b1, 32'hABCD_0002}) begin n_err++; $display("FAIL held_second got=%0h exp=%0h", {i_valid, i_rdata}, {1'b1, 32'hABCD_0002}); end
    i_req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_wait_states();
    test_simultaneous();
    test_starvation();
    test_reset_mid();
    test_held_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
